// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// State encoding, blank patterns and digit count.
package seg_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_e;

  localparam logic [6:0] SEG_BLANK  = 7'b1111111;
  localparam logic [3:0] AN_OFF     = 4'b1111;
  localparam int         NUM_DIGITS = 4;

endpackage

// File: rtl/seg_scan_driver_bcd7seg.sv
// BCD to seven-segment decoder, active-low cathodes {g,f,e,d,c,b,a}.
// Ports: bcd_i (nibble in), seg_o (cathodes; non-BCD codes blank).
module seg_scan_driver_bcd7seg
  import seg_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_o = 7'b1000000;
      4'd1:    seg_o = 7'b1111001;
      4'd2:    seg_o = 7'b0100100;
      4'd3:    seg_o = 7'b0110000;
      4'd4:    seg_o = 7'b0011001;
      4'd5:    seg_o = 7'b0010010;
      4'd6:    seg_o = 7'b0000010;
      4'd7:    seg_o = 7'b1111000;
      4'd8:    seg_o = 7'b0000000;
      4'd9:    seg_o = 7'b0010000;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// 4-digit common-anode scan driver: per-frame snapshot, blank gap per digit.
// Ports: clk, rst, digits/digit_en/dp_in in; an/seg/dp/frame_done out (all registered).
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int SHOW_TICKS  = 100000,
  parameter int BLANK_TICKS = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits,
  input  logic [3:0]  digit_en,
  input  logic [3:0]  dp_in,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int MAXT = (SHOW_TICKS > BLANK_TICKS) ?
                        SHOW_TICKS : BLANK_TICKS;
  localparam int CW   = (MAXT > 1) ? $clog2(MAXT) : 1;

  localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_TICKS - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_TICKS - 1);
  localparam logic [1:0]    IDX_LAST   = 2'(NUM_DIGITS - 1);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    idx_q;
  logic [15:0]   dig_q;
  logic [3:0]    en_q;
  logic [3:0]    dpm_q;
  logic [3:0]    an_q;
  logic [6:0]    seg_q;
  logic          dp_q;
  logic          fd_q;

  logic [3:0] nib;
  logic [6:0] dec;
  logic       lit;
  logic [3:0] an_d;
  logic [6:0] seg_d;
  logic       dp_d;

  assign nib = dig_q[{idx_q, 2'b00} +: 4];

  seg_scan_driver_bcd7seg u_dec (
    .bcd_i (nib),
    .seg_o (dec)
  );

  // Pattern for the digit about to be shown; only loaded on BLANK->SHOW.
  always_comb begin
    lit   = en_q[idx_q];
    an_d  = AN_OFF;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (lit) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = dec;
      dp_d  = ~dpm_q[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LOAD;
      cnt_q   <= '0;
      idx_q   <= '0;
      dig_q   <= '0;
      en_q    <= '0;
      dpm_q   <= '0;
      an_q    <= AN_OFF;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
      fd_q    <= 1'b0;
    end else begin
      fd_q <= 1'b0;
      unique case (state_q)
        ST_LOAD: begin
          dig_q   <= digits;
          en_q    <= digit_en;
          dpm_q   <= dp_in;
          idx_q   <= '0;
          cnt_q   <= '0;
          state_q <= ST_BLANK;
        end
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            cnt_q   <= '0;
            state_q <= ST_SHOW;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            cnt_q <= '0;
            an_q  <= AN_OFF;
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b1;
            if (idx_q == IDX_LAST) begin
              state_q <= ST_LOAD;
              fd_q    <= 1'b1;
            end else begin
              idx_q   <= idx_q + 2'd1;
              state_q <= ST_BLANK;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= ST_LOAD;
          cnt_q   <= '0;
          an_q    <= AN_OFF;
          seg_q   <= SEG_BLANK;
          dp_q    <= 1'b1;
        end
      endcase
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver (SHOW=4, BLANK=2, 25-cycle frame).
// Frame-position reference model plus directed scenario checks.
module tb_seg_scan_driver;

  localparam int S  = 4;
  localparam int B  = 2;
  localparam int SL = S + B;
  localparam int FR = 1 + 4 * SL;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] digits = '0;
  logic [3:0]  digit_en = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  always #5 clk = ~clk;

  seg_scan_driver #(
    .SHOW_TICKS  (S),
    .BLANK_TICKS (B)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .digits     (digits),
    .digit_en   (digit_en),
    .dp_in      (dp_in),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  int n_cmp = 0;
  int n_err = 0;

  int          pos   = 0;
  bit          fresh = 1'b1;
  logic [15:0] s_dig = '0;
  logic [3:0]  s_en  = '0;
  logic [3:0]  s_dp  = '0;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic        e_fd;

  function automatic logic [6:0] ref_seg(input logic [3:0] v);
    case (v)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Advance one clock; the model tracks position within the frame.
  task automatic tick();
    int q;
    int sl;
    @(posedge clk);
    if (rst) begin
      pos   = 0;
      fresh = 1'b1;
    end else begin
      if (pos == 0) begin
        s_dig = digits;
        s_en  = digit_en;
        s_dp  = dp_in;
      end
      pos = (pos + 1) % FR;
      if (pos == 0) fresh = 1'b0;
    end
    #1;
    e_an  = 4'b1111;
    e_seg = 7'b1111111;
    e_dp  = 1'b1;
    e_fd  = 1'b0;
    if (pos == 0) begin
      e_fd = !fresh;
    end else begin
      q  = pos - 1;
      sl = q / SL;
      if ((q % SL) >= B && s_en[sl]) begin
        e_an[sl] = 1'b0;
        e_seg    = ref_seg(s_dig[sl*4 +: 4]);
        e_dp     = ~s_dp[sl];
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      digits   = 16'($urandom);
      digit_en = 4'($urandom);
      dp_in    = 4'($urandom);
      tick();
      n_cmp++;
      if ({an, seg, dp, frame_done} !== {4'hf, 7'h7f, 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL reset cyc=%0d an=%b seg=%b dp=%b fd=%b exp 1111/1111111/1/0",
                 i, an, seg, dp, frame_done);
      end
    end
    digits   = 16'h1234;
    digit_en = 4'hf;
    dp_in    = 4'h0;
    rst      = 1'b0;
    tick();
    n_cmp++;
    if (an !== 4'b1111 || frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release an=%b fd=%b exp 1111/0", an, frame_done);
    end
  endtask

  task automatic test_full_scan();
    logic [3:0] xa;
    logic [6:0] xs;
    for (int i = 0; i < 2 * FR; i++) begin
      tick();
      n_cmp++;
      if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
        n_err++;
        $display("FAIL scan pos=%0d an=%b seg=%b dp=%b fd=%b exp %b %b %b %b",
                 pos, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
      end
      n_cmp++;
      if ($countones(~an) > 1) begin
        n_err++;
        $display("FAIL scan_overlap an=%b exp at most one low", an);
      end
      if (pos > 0 && ((pos - 1) % SL) >= B) begin
        case ((pos - 1) / SL)
          0:       begin xa = 4'b1110; xs = 7'b0011001; end
          1:       begin xa = 4'b1101; xs = 7'b0110000; end
          2:       begin xa = 4'b1011; xs = 7'b0100100; end
          default: begin xa = 4'b0111; xs = 7'b1111001; end
        endcase
        n_cmp++;
        if (an !== xa || seg !== xs) begin
          n_err++;
          $display("FAIL scan_slot pos=%0d an=%b seg=%b exp %b %b",
                   pos, an, seg, xa, xs);
        end
      end
    end
  endtask

  task automatic test_snapshot();
    int fdc;
    for (int i = 0; i < 2 * FR && pos != 10; i++) tick();
    n_cmp++;
    if (pos != 10) begin
      n_err++;
      $display("FAIL snap_align pos=%0d exp 10", pos);
    end
    digits = 16'h5678;
    fdc    = 0;
    for (int i = 0; i < 2 * FR; i++) begin
      tick();
      if (frame_done === 1'b1) fdc++;
      n_cmp++;
      if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
        n_err++;
        $display("FAIL snap pos=%0d an=%b seg=%b dp=%b fd=%b exp %b %b %b %b",
                 pos, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
      end
      if (fdc == 0 && pos >= 15 && pos <= 18) begin
        n_cmp++;
        if (seg !== 7'b0100100) begin
          n_err++;
          $display("FAIL snap_old pos=%0d seg=%b exp 0100100", pos, seg);
        end
      end
      if (fdc == 1 && pos >= 3 && pos <= 6) begin
        n_cmp++;
        if (an !== 4'b1110 || seg !== 7'b0000000) begin
          n_err++;
          $display("FAIL snap_new pos=%0d an=%b seg=%b exp 1110 0000000",
                   pos, an, seg);
        end
      end
      if (i == FR - 1) begin
        n_cmp++;
        if (fdc != 1) begin
          n_err++;
          $display("FAIL snap_fd count=%0d exp 1", fdc);
        end
      end
    end
  endtask

  task automatic test_enable();
    int lit0;
    digits   = 16'h0A00;
    digit_en = 4'b0101;
    lit0     = 0;
    for (int i = 0; i < 2 * FR; i++) begin
      tick();
      n_cmp++;
      if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
        n_err++;
        $display("FAIL enable pos=%0d an=%b seg=%b dp=%b fd=%b exp %b %b %b %b",
                 pos, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
      end
      if (i >= FR) begin
        if (an === 4'b1110) lit0++;
        n_cmp++;
        if (an === 4'b1101 || an === 4'b0111 ||
            (an === 4'b1011 && seg !== 7'b1111111) ||
            (an === 4'b1110 && seg !== 7'b1000000)) begin
          n_err++;
          $display("FAIL enable_slot an=%b seg=%b", an, seg);
        end
      end
    end
    n_cmp++;
    if (lit0 != S) begin
      n_err++;
      $display("FAIL enable_lit0 count=%0d exp %0d", lit0, S);
    end
  endtask

  task automatic test_dp();
    int dpc;
    digits   = 16'h1234;
    digit_en = 4'hf;
    dp_in    = 4'b0010;
    dpc      = 0;
    for (int i = 0; i < 2 * FR; i++) begin
      tick();
      n_cmp++;
      if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
        n_err++;
        $display("FAIL dp pos=%0d an=%b seg=%b dp=%b fd=%b exp %b %b %b %b",
                 pos, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
      end
      if (i >= FR && dp === 1'b0) begin
        dpc++;
        n_cmp++;
        if (an !== 4'b1101) begin
          n_err++;
          $display("FAIL dp_slot an=%b exp 1101 while dp low", an);
        end
      end
    end
    n_cmp++;
    if (dpc != S) begin
      n_err++;
      $display("FAIL dp_count count=%0d exp %0d", dpc, S);
    end
    dp_in = 4'h0;
  endtask

  task automatic test_reset_mid();
    int first_fd;
    for (int i = 0; i < 2 * FR && pos != 15; i++) tick();
    n_cmp++;
    if (pos != 15 || an !== 4'b1011) begin
      n_err++;
      $display("FAIL rmid_align pos=%0d an=%b exp 15 1011", pos, an);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (an !== 4'b1111 || seg !== 7'h7f || frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL rmid_dark an=%b seg=%b fd=%b exp 1111 1111111 0",
               an, seg, frame_done);
    end
    first_fd = -1;
    for (int k = 1; k <= 40 && first_fd < 0; k++) begin
      tick();
      if (frame_done === 1'b1) first_fd = k;
      if (k <= 3) begin
        n_cmp++;
        if (an !== ((k == 3) ? 4'b1110 : 4'b1111)) begin
          n_err++;
          $display("FAIL rmid_start k=%0d an=%b", k, an);
        end
      end
    end
    n_cmp++;
    if (first_fd != FR) begin
      n_err++;
      $display("FAIL rmid_fd at=%0d exp %0d", first_fd, FR);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        digits   = 16'($urandom);
        digit_en = 4'($urandom);
        dp_in    = 4'($urandom);
      end
      rst = ($urandom_range(0, 63) == 0);
      tick();
      n_cmp++;
      if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
        n_err++;
        $display("FAIL random pos=%0d an=%b seg=%b dp=%b fd=%b exp %b %b %b %b",
                 pos, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
      end
      n_cmp++;
      if ($countones(~an) > 1) begin
        n_err++;
        $display("FAIL random_overlap an=%b", an);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_snapshot();
    test_enable();
    test_dp();
    digits   = 16'h1234;
    digit_en = 4'hf;
    for (int i = 0; i < FR; i++) tick();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
